// File: rtl/wb_uart_fifo.sv
// Wishbone 8N1 UART with programmable baud divisor and TX/RX FIFOs.
// Optional feature macro UART_LOOPBACK_EN adds the LOOP bit (DIV[31]) for internal TX->RX loopback.
module wb_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RESET  = 434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        uart_irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FullCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      PtrOne  = (AW+1)'(1);
  localparam logic [DIV_W-1:0] TmrOne  = DIV_W'(1);
  localparam logic [DIV_W:0]   HalfOne = (DIV_W+1)'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic             ack_q, acc, wr, rd;
  logic [1:0]       reg_sel;
  logic [31:0]      dat_q, rdata, rx_cnt_w;
  logic [7:0]       rx_cnt_sat;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       irq_en_q;
  logic             rxovr_q, txovf_q, ferr_q, irq_q, tx_idle, unused_bits;
`ifdef UART_LOOPBACK_EN
  logic             loop_q;
`endif

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, tx_cnt, rx_wp_q, rx_rp_q, rx_cnt;
  logic        tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
  logic        rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;
  logic [7:0]  tx_head, rx_head;

  state_e           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DIV_W-1:0] tx_tmr_q, tx_tmr_d, tx_div_q, tx_div_d;
  logic [DIV_W-1:0] rx_tmr_q, rx_tmr_d, rx_div_q, rx_div_d;
  logic [DIV_W:0]   rx_half;
  logic [2:0]       tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic             tx_q, tx_d, tx_last, rx_last;
  logic             rx_line, rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_done, rx_ferr;

  assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

  assign acc      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr       = acc & wb_we_i & wb_sel_i[0];
  assign rd       = acc & ~wb_we_i;
  assign reg_sel  = wb_adr_i[3:2];
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign uart_irq = irq_q;

`ifdef UART_LOOPBACK_EN
  assign rx_line   = loop_q ? tx_q : i_uart_rx;
  assign o_uart_tx = loop_q ? 1'b1 : tx_q;
`else
  assign rx_line   = i_uart_rx;
  assign o_uart_tx = tx_q;
`endif

  assign tx_cnt     = tx_wp_q - tx_rp_q;
  assign tx_full    = (tx_cnt == FullCnt);
  assign tx_empty   = (tx_cnt == '0);
  assign tx_head    = tx_mem[tx_rp_q[AW-1:0]];
  assign tx_push    = wr & (reg_sel == 2'd0) & (~tx_full | tx_pop);
  assign tx_ovf_set = wr & (reg_sel == 2'd0) & tx_full & ~tx_pop;

  assign rx_cnt     = rx_wp_q - rx_rp_q;
  assign rx_full    = (rx_cnt == FullCnt);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_head    = rx_mem[rx_rp_q[AW-1:0]];
  assign rx_pop     = rd & (reg_sel == 2'd0) & ~rx_empty;
  assign rx_push    = rx_done & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_done & rx_full & ~rx_pop;

  assign rx_cnt_w   = 32'(rx_cnt);
  assign rx_cnt_sat = (rx_cnt_w > 32'd255) ? 8'hff : rx_cnt_w[7:0];
  assign tx_idle    = tx_empty & (tx_state_q == StIdle);
  assign tx_last    = (tx_tmr_q == tx_div_q);
  assign rx_last    = (rx_tmr_q == rx_div_q);
  assign rx_half    = ({1'b0, rx_div_q} + HalfOne) >> 1;
  assign rx_fall    = rx_prev_q & ~rx_s2_q;

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: if (!rx_empty) rdata[7:0] = rx_head;
      2'd1: begin
        rdata[5:0]  = {ferr_q, txovf_q, rxovr_q, tx_idle, tx_full, ~rx_empty};
        rdata[15:8] = rx_cnt_sat;
      end
      2'd2: begin
        rdata[DIV_W-1:0] = div_q;
`ifdef UART_LOOPBACK_EN
        rdata[31] = loop_q;
`endif
      end
      2'd3: rdata[2:0] = irq_en_q;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_div_d   = tx_div_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StIdle:  tx_pop = ~tx_empty;
      StStart: begin
        if (tx_last) begin
          tx_tmr_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = StData;
        end else tx_tmr_d = tx_tmr_q + TmrOne;
      end
      StData: begin
        if (tx_last) begin
          tx_tmr_d   = '0;
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
          tx_state_d = (tx_idx_q == 3'd7) ? StStop : StData;
        end else tx_tmr_d = tx_tmr_q + TmrOne;
      end
      StStop: begin
        if (tx_last) begin
          tx_pop     = ~tx_empty;
          tx_state_d = StIdle;
        end else tx_tmr_d = tx_tmr_q + TmrOne;
      end
      default: tx_state_d = StIdle;
    endcase
    // Every pop begins a start bit, so STOP chains directly into the next frame.
    if (tx_pop) begin
      tx_sh_d    = tx_head;
      tx_div_d   = div_q;
      tx_tmr_d   = '0;
      tx_state_d = StStart;
    end
    tx_d = (tx_state_d == StStart) ? 1'b0 : (tx_state_d == StData) ? tx_sh_d[0] : 1'b1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_div_d   = rx_div_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_fall) begin
          rx_tmr_d   = TmrOne;  // the edge-detect cycle counts toward the half bit
          rx_div_d   = div_q;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (({1'b0, rx_tmr_q} + HalfOne) >= rx_half) begin
          rx_tmr_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? StIdle : StData;
        end else rx_tmr_d = rx_tmr_q + TmrOne;
      end
      StData: begin
        if (rx_last) begin
          rx_tmr_d   = '0;
          rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          rx_state_d = (rx_idx_q == 3'd7) ? StStop : StData;
        end else rx_tmr_d = rx_tmr_q + TmrOne;
      end
      StStop: begin
        if (rx_last) begin
          rx_done    = rx_s2_q;
          rx_ferr    = ~rx_s2_q;
          rx_state_d = StIdle;
        end else rx_tmr_d = rx_tmr_q + TmrOne;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= wb_dat_i[7:0];
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      div_q      <= DIV_W'(DIV_RESET);
      irq_en_q   <= '0;
      rxovr_q    <= 1'b0;
      txovf_q    <= 1'b0;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
`ifdef UART_LOOPBACK_EN
      loop_q     <= 1'b0;
`endif
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_state_q <= StIdle;
      tx_tmr_q   <= '0;
      tx_div_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= StIdle;
      rx_tmr_q   <= '0;
      rx_div_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= wb_we_i ? 32'd0 : rdata;
      if (wr && reg_sel == 2'd2) begin
        div_q <= wb_dat_i[DIV_W-1:0];
`ifdef UART_LOOPBACK_EN
        loop_q <= wb_dat_i[31];
`endif
      end
      if (wr && reg_sel == 2'd3) irq_en_q <= wb_dat_i[2:0];
      if (wr && reg_sel == 2'd1) begin
        rxovr_q <= rxovr_q & ~wb_dat_i[3];
        txovf_q <= txovf_q & ~wb_dat_i[4];
        ferr_q  <= ferr_q & ~wb_dat_i[5];
      end
      // New events win over a same-cycle clear.
      if (rx_ovr_set) rxovr_q <= 1'b1;
      if (tx_ovf_set) txovf_q <= 1'b1;
      if (rx_ferr)    ferr_q  <= 1'b1;
      irq_q <= |(irq_en_q & {rxovr_q | txovf_q | ferr_q, tx_idle, ~rx_empty});
      if (tx_push) tx_wp_q <= tx_wp_q + PtrOne;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PtrOne;
      if (rx_push) rx_wp_q <= rx_wp_q + PtrOne;
      if (rx_pop)  rx_rp_q <= rx_rp_q + PtrOne;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_div_q   <= tx_div_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_div_q   <= rx_div_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rx_line;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule
